multi_sensor_scan_uc: RTL and testbench

Parametrised control unit for the sensor-scan/serial-report datapath. On a start request it triggers a measurement, waits an internal settling interval, then streams N_BYTES bytes for each of N_SENSORS sensors through the serial transmitter, with a timeout on every byte. It adds these behaviours:
- exposes the current sensor and byte indices;
- offers a continuous (free-running) scan mode;
- flags a stalled transmitter.

---
 rtl/multi_sensor_scan_uc.sv | 152 +++++++++++++++
 tb/tb_multi_sensor_scan_uc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sensor_scan_uc.sv
// Sensor-scan / serial-report sequencer.
// Measures once, settles, then streams every byte of every sensor.
module multi_sensor_scan_uc #(
  parameter int N_SENSORS     = 3,
  parameter int N_BYTES       = 4,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int TX_TIMEOUT    = 1000000,
  localparam int SW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic          modo_continuo,
  input  logic          pronto_serial,
  output logic          medir,
  output logic          zera_sensor,
  output logic          zera_serial,
  output logic          partida_tx,
  output logic [SW-1:0] sel_sensor,
  output logic [BW-1:0] sel_byte,
  output logic          pronto,
  output logic          erro,
  output logic [3:0]    db_estado
);

  localparam int MAXW =
    (SETTLE_CYCLES > TX_TIMEOUT) ? SETTLE_CYCLES : TX_TIMEOUT;
  localparam int CW = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TX_LAST  = CW'(TX_TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(N_SENSORS - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(N_BYTES - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    MEDIR       = 4'd1,
    ESP_SEG     = 4'd2,
    ENVIA       = 4'd3,
    ESP_TX      = 4'd4,
    PROX_BYTE   = 4'd5,
    PROX_SENSOR = 4'd6,
    FINAL       = 4'd7,
    ERRO        = 4'd8
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;

  // State, shared wait counter and byte/sensor indices
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st         <= INICIAL;
      cnt        <= '0;
      sel_sensor <= '0;
      sel_byte   <= '0;
    end else begin
      case (st)
        INICIAL: begin
          sel_sensor <= '0;
          sel_byte   <= '0;
          if (jogar) st <= MEDIR;
        end
        MEDIR: begin
          cnt <= '0;
          st  <= ESP_SEG;
        end
        ESP_SEG: begin
          cnt <= cnt + CW'(1);
          if (cnt == SET_LAST) st <= ENVIA;
        end
        ENVIA: begin
          cnt <= '0;
          st  <= ESP_TX;
        end
        ESP_TX: begin
          cnt <= cnt + CW'(1);
          if (pronto_serial)      st <= PROX_BYTE;
          else if (cnt == TX_LAST) st <= ERRO;
        end
        PROX_BYTE: begin
          if (sel_byte == B_LAST) begin
            st <= PROX_SENSOR;
          end else begin
            sel_byte <= sel_byte + BW'(1);
            st       <= ENVIA;
          end
        end
        PROX_SENSOR: begin
          sel_byte <= '0;
          if (sel_sensor == S_LAST) begin
            st <= FINAL;
          end else begin
            sel_sensor <= sel_sensor + SW'(1);
            st         <= ENVIA;
          end
        end
        FINAL: begin
          sel_sensor <= '0;
          sel_byte   <= '0;
          st <= modo_continuo ? MEDIR : INICIAL;
        end
        ERRO: begin
          if (jogar) st <= INICIAL;
        end
        default: st <= INICIAL;
      endcase
    end
  end

  // Moore output decode of the state register
  always_comb begin
    medir       = 1'b0;
    zera_sensor = 1'b0;
    zera_serial = 1'b0;
    partida_tx  = 1'b0;
    pronto      = 1'b0;
    erro        = 1'b0;
    db_estado   = 4'hF;
    case (st)
      INICIAL: begin
        zera_sensor = 1'b1;
        zera_serial = 1'b1;
        db_estado   = 4'd0;
      end
      MEDIR: begin
        medir     = 1'b1;
        db_estado = 4'd1;
      end
      ESP_SEG:     db_estado = 4'd2;
      ENVIA: begin
        partida_tx = 1'b1;
        db_estado  = 4'd3;
      end
      ESP_TX:      db_estado = 4'd4;
      PROX_BYTE:   db_estado = 4'd5;
      PROX_SENSOR: db_estado = 4'd6;
      FINAL: begin
        pronto    = 1'b1;
        db_estado = 4'd7;
      end
      ERRO: begin
        erro        = 1'b1;
        zera_serial = 1'b1;
        db_estado   = 4'd8;
      end
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_multi_sensor_scan_uc.sv
// Scoreboard bench for multi_sensor_scan_uc.
// Expected event times come from frame arithmetic.
module tb_multi_sensor_scan_uc;

  localparam int NS = 2;
  localparam int NB = 2;
  localparam int S  = 4;
  localparam int TX = 8;

  logic       clock;
  logic       reset;
  logic       jogar;
  logic       modo_continuo;
  logic       pronto_serial;
  logic       medir;
  logic       zera_sensor;
  logic       zera_serial;
  logic       partida_tx;
  logic [0:0] sel_sensor;
  logic [0:0] sel_byte;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  multi_sensor_scan_uc #(
    .N_SENSORS    (NS),
    .N_BYTES      (NB),
    .SETTLE_CYCLES(S),
    .TX_TIMEOUT   (TX)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .jogar        (jogar),
    .modo_continuo(modo_continuo),
    .pronto_serial(pronto_serial),
    .medir        (medir),
    .zera_sensor  (zera_sensor),
    .zera_serial  (zera_serial),
    .partida_tx   (partida_tx),
    .sel_sensor   (sel_sensor),
    .sel_byte     (sel_byte),
    .pronto       (pronto),
    .erro         (erro),
    .db_estado    (db_estado)
  );

  typedef struct {
    int k;
    int s;
    int b;
    int t;
  } ev_t;

  localparam logic [11:0] IDLE = 12'b0000_110000_00;

  ev_t  evq[$];
  int   dq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   cont_until = 0;
  int   tgt = -1;
  logic erro_q = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [11:0] outs();
    return {db_estado, zera_sensor, zera_serial, medir,
            partida_tx, pronto, erro, sel_sensor, sel_byte};
  endfunction

  function automatic logic [31:0] pk(int k, int s, int b, int t);
    return {k[3:0], s[3:0], b[3:0], t[19:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic exp_ev(input int k, input int s, input int b,
                        input int t);
    ev_t ev;
    ev.k = k;
    ev.s = s;
    ev.b = b;
    ev.t = t;
    evq.push_back(ev);
  endtask

  task automatic see(input int k, input int s, input int b);
    ev_t e;
    if (evq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event: got kind %0d (%0d,%0d) at %0d required none",
               k, s, b, cyc);
    end else begin
      e = evq.pop_front();
      check("event", pk(k, s, b, cyc), pk(e.k, e.s, e.b, e.t));
    end
  endtask

  // monitor: every output pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (medir)          see(0, 0, 0);
      if (partida_tx)     see(1, int'(sel_sensor), int'(sel_byte));
      if (pronto)         see(2, 0, 0);
      if (erro && !erro_q) see(3, 0, 0);
    end
    erro_q <= erro;
  end

  // transmitter model: answers each byte after its planned delay
  always @(negedge clock) begin
    int d;
    pronto_serial = 1'b0;
    if (partida_tx) begin
      d = (dq.size() > 0) ? dq.pop_front() : 1;
      tgt = (d > 0) ? cyc + d : -1;
      pronto_serial = 1'($urandom_range(0, 1));
    end else if (cyc == tgt) begin
      pronto_serial = 1'b1;
    end
    modo_continuo = (cyc < cont_until);
  end

  // kind: 0 random, 1 last-allowed reply, 2 timeout, 3 reset mid-frame
  task automatic run_frame(input int nfr, input bit cont,
                           input int kind, output int rst_cyc);
    int m;
    int e;
    int d;
    jogar = 1'b1;
    dq.delete();
    rst_cyc = 0;
    m = cyc + 1;
    e = 0;
    for (int fr = 0; fr < nfr; fr++) begin
      exp_ev(0, 0, 0, m);
      e = m + S + 1;
      for (int s = 0; s < NS; s++) begin
        for (int b = 0; b < NB; b++) begin
          exp_ev(1, s, b, e);
          if (kind == 2) begin
            exp_ev(3, 0, 0, e + TX + 1);
            dq.push_back(0);
            cont_until = 0;
            return;
          end
          if (kind == 3 && s == 1 && b == 0) begin
            dq.push_back(0);
            rst_cyc = e + 2;
            cont_until = 0;
            return;
          end
          if (kind == 1 && b == 0) d = TX;
          else d = $urandom_range(1, TX);
          dq.push_back(d);
          e = e + d + 1;
          if (b == NB - 1) e = e + 1;
          e = e + 1;
        end
      end
      exp_ev(2, 0, 0, e);
      m = e + 1;
    end
    cont_until = cont ? e : 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (evq.size() > 0 && n < 600) begin
      @(negedge clock);
      n++;
    end
    check("frame_done", evq.size(), 0);
    evq.delete();
  endtask

  initial begin
    int r;
    jogar = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_state", outs(), IDLE);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("idle", outs(), IDLE);
    end

    repeat (3) begin
      run_frame(1, 1'b0, 0, r);
      @(negedge clock);
      jogar = 1'b0;
      wait_done();
      @(negedge clock);
      check("back_to_inicial", outs(), IDLE);
    end

    run_frame(1, 1'b0, 1, r);
    @(negedge clock);
    jogar = 1'b0;
    wait_done();
    @(negedge clock);
    check("last_allowed_end", outs(), IDLE);

    run_frame(1, 1'b0, 2, r);
    @(negedge clock);
    jogar = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
    check("erro_held", {db_estado, erro, zera_serial}, {4'd8, 2'b11});
    jogar = 1'b1;
    @(negedge clock);
    check("erro_clear", outs(), IDLE);
    jogar = 1'b0;
    repeat (2) @(negedge clock);

    run_frame(3, 1'b1, 0, r);
    @(negedge clock);
    jogar = 1'b0;
    wait_done();
    @(negedge clock);
    check("cont_end", outs(), IDLE);

    run_frame(1, 1'b0, 3, r);
    @(negedge clock);
    jogar = 1'b0;
    while (cyc < r) @(negedge clock);
    check("pre_reset_events", evq.size(), 0);
    check("pre_reset_state", db_estado, 4'd4);
    reset = 1'b0;
    #1;
    check("async_reset", outs(), IDLE);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_frame(1, 1'b0, 0, r);
    @(negedge clock);
    jogar = 1'b0;
    wait_done();
    @(negedge clock);
    check("post_reset_frame", outs(), IDLE);

    check("queue_empty", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
